instr_fetch_unit: RTL and testbench

//  Reads the program: owns the fetch PC and issues read requests to instruction memory.

---
 rtl/instr_fetch_unit_pkg.sv | 22 ++
 rtl/instr_fetch_unit_fetch_out_reg.sv | 53 +++++
 rtl/instr_fetch_unit.sv | 113 +++++++++++
 tb/tb_instr_fetch_unit.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// PC increment and the default reset PC.
package instr_fetch_unit_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_DROP = 3'd3;
  localparam logic [2:0] ST_HOLD = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    REQ  = ST_REQ,
    WAIT = ST_WAIT,
    DROP = ST_DROP,
    HOLD = ST_HOLD
  } fetch_state_e;

  localparam int unsigned PC_INC           = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

endpackage

// File: rtl/instr_fetch_unit_fetch_out_reg.sv
// Holding register for the instruction presented to decode; load captures a
// new {PC, instruction}, clear drops valid but leaves the payload untouched.
module instr_fetch_unit_fetch_out_reg
  import instr_fetch_unit_pkg::*;
#(
  parameter int N       = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [N-1:0]       pc_in,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [N-1:0]       pc
);

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [N-1:0]       pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (load) begin
      valid_d = 1'b1;
      instr_d = instr_in;
      pc_d    = pc_in;
    end else if (clear) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc    = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues one memory read at a time,
// hands {PC, instruction} to decode and discards responses made stale by redirects.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int           N        = 32,
  parameter int           INSTR_W  = 32,
  parameter logic [N-1:0] RESET_PC = N'(DEFAULT_RESET_PC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic [N-1:0]       redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [N-1:0]       imem_req_addr,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [N-1:0]       dec_pc
);

  fetch_state_e state_q, state_d;
  logic [N-1:0] fetch_pc_q, fetch_pc_d;
  logic [N-1:0] redirect_target;
  logic         out_load, out_clear;
  logic         redirect_lsb_unused;

  // Instructions are word aligned, so the low target bits are simply dropped.
  assign redirect_target     = {redirect_pc[N-1:2], 2'b00};
  assign redirect_lsb_unused = ^redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    out_load       = 1'b0;
    out_clear      = 1'b0;
    imem_req_valid = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect_valid) fetch_pc_d = redirect_target;
      end
      REQ: begin
        imem_req_valid = 1'b1;
        // A request accepted together with a redirect fetches the wrong address.
        if (redirect_valid) begin
          fetch_pc_d = redirect_target;
          if (imem_req_ready) state_d = DROP;
        end else if (imem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_resp_valid) begin
          if (redirect_valid) begin
            state_d    = REQ;
            fetch_pc_d = redirect_target;
          end else begin
            state_d    = HOLD;
            out_load   = 1'b1;
            fetch_pc_d = fetch_pc_q + N'(PC_INC);
          end
        end else if (redirect_valid) begin
          state_d    = DROP;
          fetch_pc_d = redirect_target;
        end
      end
      DROP: begin
        if (redirect_valid)  fetch_pc_d = redirect_target;
        if (imem_resp_valid) state_d    = REQ;
      end
      HOLD: begin
        if (redirect_valid) fetch_pc_d = redirect_target;
        if (dec_ready || redirect_valid) begin
          state_d   = REQ;
          out_clear = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_req_addr = fetch_pc_q;

  instr_fetch_unit_fetch_out_reg #(
    .N       (N),
    .INSTR_W (INSTR_W)
  ) u_out_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (out_load),
    .clear    (out_clear),
    .instr_in (imem_resp_data),
    .pc_in    (fetch_pc_q),
    .valid    (dec_valid),
    .instr    (dec_instr),
    .pc       (dec_pc)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a memory/redirect model predicts the
// delivered {PC, instruction} stream and the next request address.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;

  logic        wrap_req_valid;
  logic [31:0] wrap_req_addr;
  logic        wrap_dec_valid;
  logic [31:0] wrap_dec_instr;
  logic [31:0] wrap_dec_pc;

  instr_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .dec_instr       (dec_instr),
    .dec_pc          (dec_pc)
  );

  // Same stimulus as dut, so its timing is identical; only its PCs differ.
  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk             (clk),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (wrap_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (wrap_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .dec_valid       (wrap_dec_valid),
    .dec_ready       (dec_ready),
    .dec_instr       (wrap_dec_instr),
    .dec_pc          (wrap_dec_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int delivered = 0;

  bit          rst_k, redir_k, rready_k, dready_k, force_resp_k, ovr_en;
  logic [31:0] redir_pc_k, ovr_data;
  int          lat_k;

  logic [31:0] model_pc;
  bit          mem_busy, mem_stale;
  logic [31:0] mem_addr;
  int          mem_cnt;
  bit          acc_now;
  logic [63:0] exp_q[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs and advances the model to what the next edge must do.
  task automatic applyStimulus();
    bit resp_now;
    resp_now        = 1'b0;
    acc_now         = 1'b0;
    reset           = rst_k;
    redirect_valid  = redir_k;
    redirect_pc     = redir_pc_k;
    imem_req_ready  = rready_k;
    dec_ready       = dready_k;
    imem_resp_valid = 1'b0;
    imem_resp_data  = $urandom;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        resp_now        = 1'b1;
        imem_resp_valid = 1'b1;
        imem_resp_data  = ovr_en ? ovr_data : $urandom;
      end
    end
    if (force_resp_k) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'hBAD0_BAD0;
    end
    if (rst_k) begin
      mem_busy = 1'b0;
      exp_q.delete();
      model_pc = RESET_PC;
    end else begin
      if (resp_now) begin
        mem_busy = 1'b0;
        if (!mem_stale && !redir_k) begin
          exp_q.push_back({mem_addr, imem_resp_data});
          model_pc = mem_addr + 32'd4;
        end
      end
      if (imem_req_valid === 1'b1 && rready_k) begin
        acc_now = 1'b1;
        checkOutput("req_addr", imem_req_addr, model_pc);
        mem_busy  = 1'b1;
        mem_stale = 1'b0;
        mem_addr  = model_pc;
        mem_cnt   = lat_k;
      end
      if (redir_k) begin
        model_pc = redir_pc_k & 32'hFFFF_FFFC;
        if (mem_busy) mem_stale = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    applyStimulus();
  endtask

  task automatic waitPresent(input int max);
    bit seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (dec_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      applyStimulus();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL wait_dec_valid actual=timeout required=dec_valid within %0d cycles", max);
      @(negedge clk);
    end
  endtask

  task automatic waitReqValid(input int max);
    bit seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (imem_req_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      applyStimulus();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL wait_req_valid actual=timeout required=req_valid within %0d cycles", max);
      @(negedge clk);
    end
  endtask

  // Monitor: every new presentation to decode pops the oldest expected item.
  initial begin
    bit          prev_v;
    logic [63:0] held;
    prev_v = 1'b0;
    held   = '0;
    forever begin
      @(posedge clk);
      #1;
      if (dec_valid === 1'b1) begin
        checkOutput("req_valid_in_hold", {31'd0, imem_req_valid}, 32'd0);
        if (!prev_v) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL dec_unexpected actual pc=%h instr=%h required=no output", dec_pc, dec_instr);
            held = {dec_pc, dec_instr};
          end else begin
            held = exp_q.pop_front();
            delivered++;
            checkOutput("dec_pc", dec_pc, held[63:32]);
            checkOutput("dec_instr", dec_instr, held[31:0]);
          end
        end else begin
          checkOutput("dec_pc_stable", dec_pc, held[63:32]);
          checkOutput("dec_instr_stable", dec_instr, held[31:0]);
        end
      end
      prev_v = (dec_valid === 1'b1);
    end
  end

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = '0; dec_ready = 1'b0;
    rst_k = 1'b1; redir_k = 1'b0; redir_pc_k = '0; rready_k = 1'b1; dready_k = 1'b1;
    force_resp_k = 1'b0; ovr_en = 1'b0; ovr_data = '0; lat_k = 1;
    model_pc = RESET_PC; mem_busy = 1'b0; mem_stale = 1'b0; mem_addr = '0; mem_cnt = 0;

    // Reset, first request and first delivery (both reset PCs).
    repeat (3) step();
    rst_k = 1'b0;
    @(negedge clk);
    checkOutput("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    checkOutput("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
    checkOutput("rst_dec_instr", dec_instr, 32'd0);
    checkOutput("rst_dec_pc", dec_pc, 32'd0);
    applyStimulus();
    @(negedge clk);
    checkOutput("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
    checkOutput("first_req_addr", imem_req_addr, 32'h0040_0000);
    ovr_en = 1'b1; ovr_data = 32'h0050_0293; dready_k = 1'b0;
    applyStimulus();
    waitPresent(10);
    checkOutput("first_dec_instr", dec_instr, 32'h0050_0293);
    checkOutput("wrap_first_dec_pc", wrap_dec_pc, 32'hFFFF_FFFC);

    // Decode stall for five cycles, then release.
    applyStimulus();
    repeat (4) step();
    dready_k = 1'b1; ovr_en = 1'b0;
    step();
    waitReqValid(10);
    checkOutput("second_req_addr", imem_req_addr, 32'h0040_0004);
    checkOutput("wrap_second_req_addr", wrap_req_addr, 32'h0000_0000);

    // Redirect while waiting; the late 0xDEADBEEF must never reach decode.
    lat_k = 3;
    applyStimulus();
    redir_k = 1'b1; redir_pc_k = 32'h0040_0100;
    step();
    redir_k = 1'b0; ovr_en = 1'b1; ovr_data = 32'hDEAD_BEEF;
    step();
    step();
    ovr_en = 1'b0;
    waitReqValid(10);
    checkOutput("redirect_req_addr", imem_req_addr, 32'h0040_0100);

    // Redirect in the same cycle as the response.
    lat_k = 2;
    applyStimulus();
    step();
    redir_k = 1'b1; redir_pc_k = 32'h0040_0202;
    step();
    redir_k = 1'b0;
    waitReqValid(10);
    checkOutput("same_cycle_redirect_addr", imem_req_addr, 32'h0040_0200);
    lat_k = 1;
    applyStimulus();
    waitPresent(10);
    applyStimulus();

    // Reset while waiting, with a late response around the reset.
    waitReqValid(10);
    lat_k = 3;
    applyStimulus();
    rst_k = 1'b1; force_resp_k = 1'b1;
    step();
    rst_k = 1'b0;
    @(negedge clk);
    checkOutput("rst_wait_dec_valid", {31'd0, dec_valid}, 32'd0);
    checkOutput("rst_wait_req_valid", {31'd0, imem_req_valid}, 32'd0);
    applyStimulus();
    force_resp_k = 1'b0;
    @(negedge clk);
    checkOutput("rst_wait_restart_addr", imem_req_addr, RESET_PC);
    lat_k = 1; dready_k = 1'b0;
    applyStimulus();

    // Reset while holding an instruction.
    waitPresent(10);
    rst_k = 1'b1;
    applyStimulus();
    rst_k = 1'b0;
    @(negedge clk);
    checkOutput("rst_hold_dec_valid", {31'd0, dec_valid}, 32'd0);
    checkOutput("rst_hold_dec_pc", dec_pc, 32'd0);
    checkOutput("rst_hold_dec_instr", dec_instr, 32'd0);
    applyStimulus();
    waitReqValid(10);
    checkOutput("rst_hold_restart_addr", imem_req_addr, RESET_PC);
    applyStimulus();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      rst_k    = ($urandom_range(0, 299) == 0);
      redir_k  = ($urandom_range(0, 9) == 0);
      rready_k = ($urandom_range(0, 3) != 0);
      dready_k = ($urandom_range(0, 1) != 0);
      lat_k    = int'($urandom_range(1, 4));
      if ($urandom_range(0, 3) == 0)
        redir_pc_k = 32'hFFFF_FFF0 | $urandom_range(0, 15);
      else
        redir_pc_k = 32'h0040_0000 | ($urandom_range(0, 1023) << 2) | $urandom_range(0, 3);
      step();
    end

    // Drain: everything predicted must have been delivered.
    rst_k = 1'b0; redir_k = 1'b0; rready_k = 1'b1; dready_k = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (exp_q.size() == 0 && !mem_busy && dec_valid !== 1'b1) break;
      step();
    end
    checkOutput("drain_queue_empty", exp_q.size(), 32'd0);
    checks++;
    if (delivered < 20) begin
      errors++;
      $display("[TB] FAIL delivered_count actual=%0d required>=20", delivered);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
